// File: rtl/long_imul_if.sv
// Start/ready handshake and operand/product bus for the iterative multiplier.
interface long_imul_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               start;
  logic               signd;
  logic               ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output multiplicand, multiplier, start, signd,
    input  ready, product
  );

  modport slave (
    input  multiplicand, multiplier, start, signd,
    output ready, product
  );
endinterface

// File: rtl/long_imul.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU, producing {hi, lo}.
// Signed operands are multiplied as magnitudes and the sign is reapplied
// on the output, so the datapath itself is purely unsigned.
module long_imul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        nrst,
  long_imul_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      count;
  logic               neg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               zero_op;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  // Operand magnitudes and partial-product sum for the current step.
  always_comb begin
    abs_a   = (bus.signd && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
    abs_b   = (bus.signd && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
    zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
    sum     = acc + (mq[0] ? {1'b0, mcand} : '0);
  end

  // Load on start, otherwise shift-add one bit per edge while counting down.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      count <= '0;
      neg   <= 1'b0;
    end else if (bus.start) begin
      acc <= '0;
      if (zero_op) begin
        mq    <= '0;
        neg   <= 1'b0;
        count <= '0;
      end else begin
        mq    <= abs_b;
        mcand <= abs_a;
        neg   <= bus.signd & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
        count <= CW'(WIDTH);
      end
    end else if (count != '0) begin
      {acc, mq} <= {1'b0, sum, mq[WIDTH-1:1]};
      count     <= count - 1'b1;
    end
  end

  // Product is formed from latched state only; ready drops as soon as start arrives.
  always_comb begin
    raw         = {acc[WIDTH-1:0], mq};
    bus.product = neg ? -raw : raw;
    bus.ready   = (count == '0) && !bus.start;
  end
endmodule

// File: tb/tb_long_imul.sv
// Scoreboard bench for long_imul: stimulus pushes expected products, a
// monitor pops and compares on each rising edge of ready.
module tb_long_imul;
  logic clk;
  logic nrst;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];

  long_imul_if #(.WIDTH(32)) bus ();

  long_imul #(.WIDTH(32)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a rising edge of ready presents a result to the scoreboard.
  logic prev_ready;
  initial begin
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h expected none", bus.product);
        end else begin
          check("scoreboard_product", bus.product, exp_q.pop_front());
        end
      end
      prev_ready = bus.ready;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk);
    #1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.signd        = s;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!bus.ready && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check(nm, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int exp_lat);
    exp_q.push_back(exp);
    issue(a, b, s);
    wait_ready(nm, exp_lat);
  endtask

  task automatic hold_check(input logic [63:0] exp);
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      bus.signd        = ~bus.signd;
      @(negedge clk);
      check("hold_product", bus.product, exp);
      check("hold_ready", 64'(bus.ready), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] rexp;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    int wait_cnt;

    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.start        = 1'b0;
    bus.signd        = 1'b0;
    #22;
    check("reset_ready", 64'(bus.ready), 64'd1);
    check("reset_product", bus.product, 64'd0);
    nrst = 1'b1;

    run_op("lat_umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 32);
    hold_check(64'hFFFFFFFE_00000001);
    run_op("lat_neg3x7", 32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB, 32);
    run_op("lat_u_fd_x7", 32'hFFFFFFFD, 32'd7, 1'b0, 64'h00000006_FFFFFFEB, 32);
    run_op("lat_minxmin", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 32);
    run_op("lat_minx1", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000, 32);
    run_op("lat_u_min_x2", 32'h80000000, 32'd2, 1'b0, 64'h00000001_00000000, 32);
    run_op("lat_zero_u", 32'd0, 32'h12345678, 1'b0, 64'd0, 0);
    run_op("lat_zero_s", 32'd0, 32'h12345678, 1'b1, 64'd0, 0);
    run_op("lat_zero_b", 32'hFFFFFFFF, 32'd0, 1'b1, 64'd0, 0);

    // Restart while busy: only the second product may ever be presented.
    issue(32'd5, 32'd6, 1'b0);
    repeat (9) @(posedge clk);
    run_op("lat_restart", 32'h10000, 32'h10000, 1'b0, 64'h00000001_00000000, 32);

    // Reset mid-operation: the abort presents a zero product immediately.
    exp_q.push_back(64'd0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_product", bus.product, 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    run_op("lat_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, 32);

    // Random pairs against a plain arithmetic reference.
    for (int unsigned i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = (i % 10 == 3) ? 32'd0 : $urandom;
      rs = 1'($urandom_range(0, 1));
      sa = 64'($signed(ra));
      sb = 64'($signed(rb));
      rexp = rs ? 64'(sa * sb) : ({32'd0, ra} * {32'd0, rb});
      run_op("lat_rand", ra, rb, rs, rexp, (ra == 0 || rb == 0) ? 0 : 32);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
